// File: rtl/phys_reg_ready_table_pkg.sv
// rtl/phys_reg_ready_table_pkg.sv - shared sizing constants and tag type for the ready table
package phys_reg_ready_table_pkg;
  localparam int PHYS_REG_ADDR_WIDTH = 6;
  localparam int NUM_PREGS           = 2 ** PHYS_REG_ADDR_WIDTH;
  localparam int ISSUE_WIDTH         = 3;
  localparam int NUM_LOOKUPS         = 6;
  localparam int COUNT_WIDTH         = PHYS_REG_ADDR_WIDTH + 1;

  typedef logic [PHYS_REG_ADDR_WIDTH-1:0] preg_t;

  localparam preg_t PREG_ZERO = '0;
endpackage

// File: rtl/phys_reg_ready_table_if.sv
// rtl/phys_reg_ready_table_if.sv - common data bus broadcast channels (valid + destination tag)
interface cdb_if;
  import phys_reg_ready_table_pkg::*;

  logic  cdb_valid_0;
  logic  cdb_valid_1;
  logic  cdb_valid_2;
  preg_t cdb_dest_reg_0;
  preg_t cdb_dest_reg_1;
  preg_t cdb_dest_reg_2;

  modport master (
    output cdb_valid_0, cdb_valid_1, cdb_valid_2,
    output cdb_dest_reg_0, cdb_dest_reg_1, cdb_dest_reg_2
  );

  modport slave (
    input cdb_valid_0, cdb_valid_1, cdb_valid_2,
    input cdb_dest_reg_0, cdb_dest_reg_1, cdb_dest_reg_2
  );

  modport register_file (
    input cdb_valid_0, cdb_valid_1, cdb_valid_2,
    input cdb_dest_reg_0, cdb_dest_reg_1, cdb_dest_reg_2
  );
endinterface

// File: rtl/phys_reg_ready_table_popcount_ready.sv
// rtl/phys_reg_ready_table_popcount_ready.sv - parameterised population counter
module popcount_ready #(
  parameter int N = 64,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule

// File: rtl/phys_reg_ready_table.sv
// rtl/phys_reg_ready_table.sv - per-preg ready scoreboard with CDB wakeup and dispatch lookups
module phys_reg_ready_table
  import phys_reg_ready_table_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  cdb_if.register_file                      cdb,
  input  logic  [ISSUE_WIDTH-1:0]           alloc_valid_i,
  input  preg_t [ISSUE_WIDTH-1:0]           alloc_preg_i,
  input  preg_t [NUM_LOOKUPS-1:0]           src_preg_i,
  output logic  [NUM_LOOKUPS-1:0]           src_ready_o,
  input  logic                              flush_i,
  input  logic  [NUM_PREGS-1:0]             flush_ready_i,
  output logic  [COUNT_WIDTH-1:0]           busy_count_o,
  output logic                              conflict_o
);

  logic [NUM_PREGS-1:0]   ready_q;
  logic [NUM_PREGS-1:0]   ready_d;
  logic [COUNT_WIDTH-1:0] busy_count_q;
  logic                   conflict_q;
  logic                   conflict_d;
  logic [NUM_PREGS-1:0]   cdb_hit;
  logic [NUM_PREGS-1:0]   alloc_hit;
  logic [COUNT_WIDTH-1:0] ready_count;

  logic [ISSUE_WIDTH-1:0] cdb_valid;
  preg_t                  cdb_dest [ISSUE_WIDTH];

  assign cdb_valid   = {cdb.cdb_valid_2, cdb.cdb_valid_1, cdb.cdb_valid_0};
  assign cdb_dest[0] = cdb.cdb_dest_reg_0;
  assign cdb_dest[1] = cdb.cdb_dest_reg_1;
  assign cdb_dest[2] = cdb.cdb_dest_reg_2;

  // Decode channels and lanes into one-hot-per-register masks; duplicates simply OR together.
  always_comb begin
    cdb_hit   = '0;
    alloc_hit = '0;
    for (int c = 0; c < ISSUE_WIDTH; c++) begin
      if (cdb_valid[c]) cdb_hit[cdb_dest[c]] = 1'b1;
      if (alloc_valid_i[c]) alloc_hit[alloc_preg_i[c]] = 1'b1;
    end
    alloc_hit[PREG_ZERO] = 1'b0;
  end

  // Lookups see registered state plus this cycle's broadcasts, never this cycle's allocations.
  always_comb begin
    src_ready_o = '0;
    for (int i = 0; i < NUM_LOOKUPS; i++) begin
      src_ready_o[i] = ready_q[src_preg_i[i]] | cdb_hit[src_preg_i[i]];
    end
  end

  always_comb begin
    if (flush_i) begin
      ready_d    = flush_ready_i;
      conflict_d = conflict_q;
    end else begin
      ready_d    = (ready_q | cdb_hit) & ~alloc_hit;
      conflict_d = conflict_q | (|(alloc_hit & cdb_hit));
    end
    ready_d[PREG_ZERO] = 1'b1;
  end

  popcount_ready #(
    .N (NUM_PREGS),
    .W (COUNT_WIDTH)
  ) u_popcount (
    .bits  (ready_d),
    .count (ready_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q      <= '1;
      busy_count_q <= '0;
      conflict_q   <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      busy_count_q <= COUNT_WIDTH'(NUM_PREGS) - ready_count;
      conflict_q   <= conflict_d;
    end
  end

  assign busy_count_o = busy_count_q;
  assign conflict_o   = conflict_q;

endmodule

// File: tb/tb_phys_reg_ready_table.sv
// tb/tb_phys_reg_ready_table.sv - vector table, scoreboard and random model check for the ready table
module tb_phys_reg_ready_table;
  import phys_reg_ready_table_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic  [ISSUE_WIDTH-1:0]  alloc_valid_i;
  preg_t [ISSUE_WIDTH-1:0]  alloc_preg_i;
  preg_t [NUM_LOOKUPS-1:0]  src_preg_i;
  logic  [NUM_LOOKUPS-1:0]  src_ready_o;
  logic                     flush_i;
  logic  [NUM_PREGS-1:0]    flush_ready_i;
  logic  [COUNT_WIDTH-1:0]  busy_count_o;
  logic                     conflict_o;

  cdb_if cdb ();

  phys_reg_ready_table dut (
    .clk           (clk),
    .reset         (reset),
    .cdb           (cdb.register_file),
    .alloc_valid_i (alloc_valid_i),
    .alloc_preg_i  (alloc_preg_i),
    .src_preg_i    (src_preg_i),
    .src_ready_o   (src_ready_o),
    .flush_i       (flush_i),
    .flush_ready_i (flush_ready_i),
    .busy_count_o  (busy_count_o),
    .conflict_o    (conflict_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                    name;
    logic  [2:0]              av;
    preg_t [2:0]              ap;
    logic  [2:0]              cv;
    preg_t [2:0]              cd;
    logic                     fl;
    logic  [NUM_PREGS-1:0]    fv;
    preg_t [NUM_LOOKUPS-1:0]  sp;
    logic  [NUM_LOOKUPS-1:0]  exp_rdy;
    logic  [COUNT_WIDTH-1:0]  exp_busy;
    logic                     exp_conf;
  } vec_t;

  typedef struct {
    string                   name;
    logic [COUNT_WIDTH-1:0]  busy;
    logic                    conf;
  } sb_t;

  localparam logic [NUM_PREGS-1:0] ALL1 = {NUM_PREGS{1'b1}};

  int  n_vec  = 0;
  int  n_fail = 0;
  sb_t sb_q[$];
  vec_t tbl[$];

  logic [NUM_PREGS-1:0] m_ready;
  logic                 m_conf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm,
                              input logic [2:0] av, input int a0, input int a1, input int a2,
                              input logic [2:0] cv, input int c0, input int c1, input int c2,
                              input logic fl, input logic [NUM_PREGS-1:0] fv,
                              input int s0, input int s1, input int s2, input int s3,
                              input logic [5:0] rdy, input int busy, input logic conf);
    vec_t v;
    v.name = nm; v.av = av; v.cv = cv; v.fl = fl; v.fv = fv;
    v.ap[0] = preg_t'(a0); v.ap[1] = preg_t'(a1); v.ap[2] = preg_t'(a2);
    v.cd[0] = preg_t'(c0); v.cd[1] = preg_t'(c1); v.cd[2] = preg_t'(c2);
    v.sp = '0;
    v.sp[0] = preg_t'(s0); v.sp[1] = preg_t'(s1); v.sp[2] = preg_t'(s2); v.sp[3] = preg_t'(s3);
    v.exp_rdy = rdy; v.exp_busy = COUNT_WIDTH'(busy); v.exp_conf = conf;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    alloc_valid_i      = v.av;
    alloc_preg_i       = v.ap;
    cdb.cdb_valid_0    = v.cv[0];
    cdb.cdb_valid_1    = v.cv[1];
    cdb.cdb_valid_2    = v.cv[2];
    cdb.cdb_dest_reg_0 = v.cd[0];
    cdb.cdb_dest_reg_1 = v.cd[1];
    cdb.cdb_dest_reg_2 = v.cd[2];
    flush_i            = v.fl;
    flush_ready_i      = v.fv;
    src_preg_i         = v.sp;
  endtask

  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk);
    drive(v);
    #1;
    chk({v.name, ".rdy"}, 64'(src_ready_o), 64'(v.exp_rdy));
    sb_q.push_back('{v.name, v.exp_busy, v.exp_conf});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.name, ".busy"}, 64'(busy_count_o), 64'(e.busy));
    chk({e.name, ".conf"}, 64'(conflict_o), 64'(e.conf));
  endtask

  initial begin
    vec_t v;
    int   cnt;
    logic hit, a, b;

    drive(mk("idle", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 1'b0, ALL1, 0, 0, 0, 0, 6'h3f, 0, 1'b0));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rdy", 64'(src_ready_o), 64'h3f);
    chk("reset.busy", 64'(busy_count_o), 64'd0);
    chk("reset.conf", 64'(conflict_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    tbl.push_back(mk("alloc40",    3'b010, 0, 40, 0, 3'b000, 0, 0, 0,  1'b0, ALL1, 40, 0, 0, 0, 6'h3f, 1, 1'b0));
    tbl.push_back(mk("busy40",     3'b000, 0, 0, 0,  3'b000, 0, 0, 0,  1'b0, ALL1, 40, 0, 0, 0, 6'h3e, 1, 1'b0));
    tbl.push_back(mk("bypass40",   3'b000, 0, 0, 0,  3'b100, 0, 0, 40, 1'b0, ALL1, 40, 0, 0, 0, 6'h3f, 0, 1'b0));
    tbl.push_back(mk("held40",     3'b000, 0, 0, 0,  3'b000, 0, 0, 0,  1'b0, ALL1, 40, 0, 0, 0, 6'h3f, 0, 1'b0));
    tbl.push_back(mk("collide7",   3'b001, 7, 0, 0,  3'b001, 7, 0, 0,  1'b0, ALL1, 7, 0, 0, 0,  6'h3f, 1, 1'b1));
    tbl.push_back(mk("busy7",      3'b000, 0, 0, 0,  3'b000, 0, 0, 0,  1'b0, ALL1, 7, 0, 0, 0,  6'h3e, 1, 1'b1));
    tbl.push_back(mk("flush_conf", 3'b000, 0, 0, 0,  3'b000, 0, 0, 0,  1'b1, ALL1, 7, 0, 0, 0,  6'h3e, 0, 1'b1));
    tbl.push_back(mk("alloc33_34", 3'b011, 33, 34, 0, 3'b000, 0, 0, 0, 1'b0, ALL1, 33, 34, 0, 0, 6'h3f, 2, 1'b1));
    tbl.push_back(mk("flush_prio", 3'b001, 35, 0, 0, 3'b001, 33, 0, 0, 1'b1, ~(64'd1 << 50), 33, 34, 35, 50, 6'h3d, 1, 1'b1));
    tbl.push_back(mk("only50",     3'b000, 0, 0, 0,  3'b000, 0, 0, 0,  1'b0, ALL1, 50, 33, 34, 35, 6'h3e, 1, 1'b1));
    tbl.push_back(mk("alloc0",     3'b111, 0, 0, 0,  3'b000, 0, 0, 0,  1'b0, ALL1, 0, 50, 0, 0, 6'h3d, 1, 1'b1));
    tbl.push_back(mk("flush_bit0", 3'b000, 0, 0, 0,  3'b000, 0, 0, 0,  1'b1, ~64'd1, 0, 50, 0, 0, 6'h3d, 0, 1'b1));
    tbl.push_back(mk("after_bit0", 3'b000, 0, 0, 0,  3'b000, 0, 0, 0,  1'b0, ALL1, 0, 50, 0, 0, 6'h3f, 0, 1'b1));
    tbl.push_back(mk("dup_alloc",  3'b011, 20, 20, 0, 3'b000, 0, 0, 0, 1'b0, ALL1, 20, 0, 0, 0, 6'h3f, 1, 1'b1));
    tbl.push_back(mk("busy20",     3'b000, 0, 0, 0,  3'b000, 0, 0, 0,  1'b0, ALL1, 20, 0, 0, 0, 6'h3e, 1, 1'b1));
    tbl.push_back(mk("dup_cdb",    3'b000, 0, 0, 0,  3'b011, 20, 20, 0, 1'b0, ALL1, 20, 0, 0, 0, 6'h3f, 0, 1'b1));
    tbl.push_back(mk("alloc12",    3'b100, 0, 0, 12, 3'b000, 0, 0, 0, 1'b0, ALL1, 12, 0, 0, 0, 6'h3f, 1, 1'b1));

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset in the middle of a cycle with preg 12 busy.
    @(negedge clk);
    drive(mk("idle", 3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 1'b0, ALL1, 12, 0, 0, 0, 6'h3f, 0, 1'b0));
    #1;
    chk("pre_reset.rdy12", 64'(src_ready_o), 64'h3e);
    reset = 1'b0;
    #1;
    chk("mid_reset.rdy", 64'(src_ready_o), 64'h3f);
    chk("mid_reset.busy", 64'(busy_count_o), 64'd0);
    chk("mid_reset.conf", 64'(conflict_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset.busy", 64'(busy_count_o), 64'd0);
    chk("post_reset.conf", 64'(conflict_o), 64'd0);

    // Fill pregs 1..63 three per cycle.
    for (int c = 0; c < 21; c++) begin
      apply(mk("fill", 3'b111, 3*c+1, 3*c+2, 3*c+3, 3'b000, 0, 0, 0, 1'b0, ALL1,
               0, 0, 0, 0, 6'h3f, 3*(c+1), 1'b0));
    end
    // Drain: duplicate on channels 0/1 first, then three per cycle, then the last one alone.
    apply(mk("drain_dup", 3'b000, 0, 0, 0, 3'b111, 1, 1, 2, 1'b0, ALL1, 1, 63, 0, 0, 6'h3d, 61, 1'b0));
    for (int k = 0; k < 20; k++) begin
      apply(mk("drain", 3'b000, 0, 0, 0, 3'b111, 3+3*k, 4+3*k, 5+3*k, 1'b0, ALL1,
               3+3*k, 63, 0, 0, 6'h3d, 61-3*(k+1), 1'b0));
    end
    apply(mk("drain_last", 3'b000, 0, 0, 0, 3'b001, 63, 0, 0, 1'b0, ALL1, 63, 63, 0, 0, 6'h3f, 0, 1'b0));

    // Random traffic against a per-register priority model.
    m_ready = ALL1;
    m_conf  = 1'b0;
    for (int n = 0; n < 300; n++) begin
      v.name = "rand";
      v.av   = 3'($urandom);
      v.cv   = 3'($urandom);
      v.fl   = ($urandom_range(0, 24) == 0);
      v.fv   = {$urandom, $urandom};
      for (int k = 0; k < 3; k++) begin
        v.ap[k] = preg_t'($urandom);
        v.cd[k] = preg_t'($urandom);
      end
      for (int i = 0; i < NUM_LOOKUPS; i++) begin
        v.sp[i] = preg_t'($urandom);
        hit = m_ready[v.sp[i]];
        for (int c = 0; c < 3; c++) if (v.cv[c] && v.cd[c] == v.sp[i]) hit = 1'b1;
        v.exp_rdy[i] = hit;
      end
      if (v.fl) begin
        m_ready = v.fv;
      end else begin
        for (int r = 1; r < NUM_PREGS; r++) begin
          a = 1'b0;
          b = 1'b0;
          for (int c = 0; c < 3; c++) begin
            if (v.av[c] && int'(v.ap[c]) == r) a = 1'b1;
            if (v.cv[c] && int'(v.cd[c]) == r) b = 1'b1;
          end
          if (a) begin
            m_ready[r] = 1'b0;
            if (b) m_conf = 1'b1;
          end else if (b) begin
            m_ready[r] = 1'b1;
          end
        end
      end
      m_ready[0] = 1'b1;
      cnt = 0;
      for (int r = 0; r < NUM_PREGS; r++) if (!m_ready[r]) cnt++;
      v.exp_busy = COUNT_WIDTH'(cnt);
      v.exp_conf = m_conf;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
